stream_hsmooth: RTL and testbench

//  Avalon-ST video pre-filter, directly upstream of the colour-detect/bounding-box stage.

---
 rtl/vision_pkg.sv | 21 ++
 rtl/hsmooth_tap.sv | 19 +
 rtl/stream_hsmooth.sv | 177 +++++++++++++++++
 tb/tb_stream_hsmooth.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vision_pkg.sv
// Shared definitions for the vision pre-filter blocks.
package vision_pkg;

  localparam int unsigned DEF_IMAGE_W = 640;
  localparam int unsigned DEF_CH_W    = 8;

  // Low nibble of an SOP descriptor beat that marks a video packet.
  localparam logic [3:0] PKT_VIDEO = 4'h0;

  typedef enum logic [1:0] {
    StIdle,
    StPend,
    StFlush
  } hs_state_e;

  // Counter width for n positions, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hsmooth_tap.sv
// Combinational [1 2 1]/4 smoothing tap for a single colour channel.
module hsmooth_tap #(
  parameter int unsigned CH_W = 8
) (
  input  logic [CH_W-1:0] a_i,
  input  logic [CH_W-1:0] b_i,
  input  logic [CH_W-1:0] c_i,
  output logic [CH_W-1:0] y_o
);

  logic [CH_W+1:0] sum;

  // Two guard bits hold the full weighted sum; result truncates towards zero.
  always_comb begin
    sum = {2'b00, a_i} + {1'b0, b_i, 1'b0} + {2'b00, c_i};
    y_o = CH_W'(sum >> 2);
  end

endmodule

// File: rtl/stream_hsmooth.sv
// Avalon-ST horizontal 3-tap RGB smoother with packet passthrough and one-beat line flush.
module stream_hsmooth
  import vision_pkg::*;
#(
  parameter int unsigned IMAGE_W = DEF_IMAGE_W,
  parameter int unsigned CH_W    = DEF_CH_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3*CH_W-1:0] sink_data,
  input  logic              sink_valid,
  output logic              sink_ready,
  input  logic              sink_sop,
  input  logic              sink_eop,
  output logic [3*CH_W-1:0] source_data,
  output logic              source_valid,
  input  logic              source_ready,
  output logic              source_sop,
  output logic              source_eop,
  input  logic              enable,
  output logic              frame_err
);

  localparam int unsigned    DW    = 3 * CH_W;
  localparam int unsigned    XW    = cnt_w(IMAGE_W);
  localparam logic [XW-1:0]  XLast = XW'(IMAGE_W - 1);

  hs_state_e         state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic              pkt_video_q, pkt_video_d;
  logic              en_q, en_d;
  logic [DW-1:0]     left_q, left_d;
  logic [DW-1:0]     hold_q, hold_d;
  logic              eop_hold_q, eop_hold_d;
  logic [DW-1:0]     out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_sop_q, out_sop_d;
  logic              out_eop_q, out_eop_d;
  logic              frame_err_q, frame_err_d;

  logic              load_ok;
  logic              accept;
  logic              last_px;
  logic [DW-1:0]     tap_c;
  logic [DW-1:0]     filt;

  // Handshake: sink stalls while the line-end pixel is being flushed.
  always_comb begin
    load_ok    = ~out_valid_q | source_ready;
    sink_ready = load_ok & (state_q != StFlush);
    accept     = sink_valid & sink_ready;
    last_px    = (x_q == XLast) | sink_eop;
    // On flush the right neighbour is replicated from the held pixel.
    tap_c      = (state_q == StFlush) ? hold_q : sink_data;
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_tap
    hsmooth_tap #(
      .CH_W (CH_W)
    ) u_tap (
      .a_i (left_q[ch*CH_W +: CH_W]),
      .b_i (hold_q[ch*CH_W +: CH_W]),
      .c_i (tap_c[ch*CH_W +: CH_W]),
      .y_o (filt[ch*CH_W +: CH_W])
    );
  end

  // Next-state: FSM, line position, packet mode latch and output register load.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    pkt_video_d = pkt_video_q;
    en_d        = en_q;
    left_d      = left_q;
    hold_d      = hold_q;
    eop_hold_d  = eop_hold_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q & ~source_ready;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    frame_err_d = 1'b0;

    if (state_q == StFlush) begin
      if (load_ok) begin
        out_valid_d = 1'b1;
        out_data_d  = filt;
        out_sop_d   = 1'b0;
        out_eop_d   = eop_hold_q;
        state_d     = StIdle;
      end
    end else if (accept) begin
      if (sink_sop) begin
        pkt_video_d = (sink_data[3:0] == PKT_VIDEO);
        en_d        = enable;
        x_d         = '0;
        out_valid_d = 1'b1;
        out_data_d  = sink_data;
        out_sop_d   = sink_sop;
        out_eop_d   = sink_eop;
        // A held pixel without its line end can never be completed.
        if (state_q == StPend) begin
          frame_err_d = 1'b1;
        end
        state_d = StIdle;
      end else begin
        if (pkt_video_q) begin
          x_d = (x_q == XLast) ? '0 : x_q + 1'b1;
        end
        if (!(pkt_video_q && en_q)) begin
          out_valid_d = 1'b1;
          out_data_d  = sink_data;
          out_sop_d   = sink_sop;
          out_eop_d   = sink_eop;
        end else begin
          unique case (state_q)
            StIdle: begin
              left_d = sink_data;
              hold_d = sink_data;
            end
            StPend: begin
              out_valid_d = 1'b1;
              out_data_d  = filt;
              out_sop_d   = 1'b0;
              out_eop_d   = 1'b0;
              left_d      = hold_q;
              hold_d      = sink_data;
            end
            default: ;
          endcase
          eop_hold_d = sink_eop;
          state_d    = last_px ? StFlush : StPend;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      x_q         <= '0;
      pkt_video_q <= 1'b0;
      en_q        <= 1'b0;
      left_q      <= '0;
      hold_q      <= '0;
      eop_hold_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      pkt_video_q <= pkt_video_d;
      en_q        <= en_d;
      left_q      <= left_d;
      hold_q      <= hold_d;
      eop_hold_q  <= eop_hold_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Registered outputs.
  always_comb begin
    source_data  = out_data_q;
    source_valid = out_valid_q;
    source_sop   = out_sop_q;
    source_eop   = out_eop_q;
    frame_err    = frame_err_q;
  end

endmodule

// File: tb/tb_stream_hsmooth.sv
// Scoreboard bench for stream_hsmooth with a 4-pixel line.
module tb_stream_hsmooth;

  localparam int unsigned IMAGE_W = 4;
  localparam int unsigned CH_W    = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] sink_data = '0;
  logic        sink_valid = 1'b0;
  logic        sink_ready;
  logic        sink_sop = 1'b0;
  logic        sink_eop = 1'b0;
  logic [23:0] source_data;
  logic        source_valid;
  logic        source_ready = 1'b1;
  logic        source_sop;
  logic        source_eop;
  logic        enable = 1'b0;
  logic        frame_err;

  stream_hsmooth #(
    .IMAGE_W (IMAGE_W),
    .CH_W    (CH_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sink_data    (sink_data),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .source_data  (source_data),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .enable       (enable),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  // Expected beats {sop, eop, data}, pushed by the driver, popped by the monitor.
  logic [25:0] exp_q[$];

  int   total = 0;
  int   bad = 0;
  int   err_cnt = 0;
  logic stall_mode = 1'b0;
  logic chk_rst = 1'b0;
  logic chk_srdy = 1'b0;
  logic srdy_exp = 1'b0;
  logic chk_err = 1'b0;
  int   err_exp = 0;
  logic tmo = 1'b0;
  logic prev_stall = 1'b0;
  logic [23:0] prev_data = '0;

  // Downstream backpressure, changed just after each rising edge.
  always @(posedge clk) begin
    #1 source_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: every comparison in the bench happens here, on the falling edge.
  always @(negedge clk) begin
    logic [25:0] e;
    if (chk_rst) begin
      total++;
      if (source_valid !== 1'b0) begin
        bad++; $display("FAIL reset_valid: got %b want 0", source_valid);
      end
      total++;
      if (frame_err !== 1'b0) begin
        bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err);
      end
      total++;
      if (sink_ready !== 1'b1) begin
        bad++; $display("FAIL reset_sink_ready: got %b want 1", sink_ready);
      end
      total++;
      if ({source_sop, source_eop, source_data} !== 26'h0) begin
        bad++;
        $display("FAIL reset_data: got %h want 0", {source_sop, source_eop, source_data});
      end
    end
    if (chk_srdy) begin
      total++;
      if (sink_ready !== srdy_exp) begin
        bad++; $display("FAIL flush_sink_ready: got %b want %b", sink_ready, srdy_exp);
      end
    end
    if (chk_err) begin
      total++;
      if (err_cnt != err_exp) begin
        bad++; $display("FAIL frame_err_cycles: got %0d want %0d", err_cnt, err_exp);
      end
    end
    if (tmo) begin
      total++; bad++;
      $display("FAIL timeout: got no progress want handshake/drain within budget");
    end
    if (reset_n) begin
      if (prev_stall) begin
        total++;
        if (source_valid !== 1'b1 || source_data !== prev_data) begin
          bad++;
          $display("FAIL hold_stable: got v=%b d=%h want v=1 d=%h",
                   source_valid, source_data, prev_data);
        end
      end
      if (source_valid && source_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_beat: got %h want nothing",
                   {source_sop, source_eop, source_data});
        end else begin
          e = exp_q.pop_front();
          if ({source_sop, source_eop, source_data} !== e) begin
            bad++;
            $display("FAIL beat: got sop=%b eop=%b d=%h want sop=%b eop=%b d=%h",
                     source_sop, source_eop, source_data, e[25], e[24], e[23:0]);
          end
        end
      end
      prev_stall = source_valid && !source_ready;
      prev_data  = source_data;
      if (frame_err) err_cnt++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic expect_beat(input logic s, input logic e, input logic [23:0] d);
    exp_q.push_back({s, e, d});
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic s, input logic e, input logic [23:0] d);
    int   n = 0;
    logic ok;
    logic done = 1'b0;
    sink_data  = d;
    sink_sop   = s;
    sink_eop   = e;
    sink_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      ok = sink_ready;
      @(posedge clk);
      if (ok) begin
        done = 1'b1;
      end else if (++n > 200) begin
        #1 tmo = 1'b1;
        @(posedge clk);
        done = 1'b1;
      end
    end
    #1;
    tmo        = 1'b0;
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      #1 tmo = 1'b1;
      @(posedge clk);
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1 tmo = 1'b0;
  endtask

  task automatic check_err(input int want);
    err_exp = want;
    chk_err = 1'b1;
    @(posedge clk);
    #1 chk_err = 1'b0;
  endtask

  logic [23:0] px [4]  = '{24'h00FF05, 24'h64FF00, 24'hC8FF00, 24'h28FF00};
  logic [23:0] flt [4] = '{24'h19FF03, 24'h64FF01, 24'h87FF00, 24'h50FF00};

  task automatic smooth_frame(input logic check_flush);
    enable = 1'b1;
    expect_beat(1'b1, 1'b0, 24'h000000);
    for (int i = 0; i < 4; i++) expect_beat(1'b0, i == 3, flt[i]);
    send(1'b1, 1'b0, 24'h000000);
    // Only the SOP beat may latch the mode.
    enable = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, i == 3, px[i]);
    if (check_flush) begin
      srdy_exp = 1'b0;
      chk_srdy = 1'b1;
      @(posedge clk);
      #1 srdy_exp = 1'b1;
      @(posedge clk);
      #1 chk_srdy = 1'b0;
    end
    drain();
  endtask

  initial begin
    // 1: reset
    @(posedge clk);
    #1 chk_rst = 1'b1;
    @(posedge clk);
    #1 chk_rst = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 2: bypass frame
    enable = 1'b0;
    expect_beat(1'b1, 1'b0, 24'h000000);
    for (int i = 0; i < 4; i++) expect_beat(1'b0, i == 3, px[i]);
    send(1'b1, 1'b0, 24'h000000);
    for (int i = 0; i < 4; i++) send(1'b0, i == 3, px[i]);
    drain();

    // 3: smoothing with one flush stall
    smooth_frame(1'b1);

    // 4: same frame under random backpressure
    stall_mode = 1'b1;
    smooth_frame(1'b0);
    stall_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 5: non-video packet passes unchanged
    enable = 1'b1;
    expect_beat(1'b1, 1'b0, 24'h00000F);
    expect_beat(1'b0, 1'b0, 24'h123456);
    expect_beat(1'b0, 1'b0, 24'hABCDEF);
    expect_beat(1'b0, 1'b1, 24'h0F0F0F);
    send(1'b1, 1'b0, 24'h00000F);
    send(1'b0, 1'b0, 24'h123456);
    send(1'b0, 1'b0, 24'hABCDEF);
    send(1'b0, 1'b1, 24'h0F0F0F);
    drain();
    check_err(0);

    // 6: early eop, then an unterminated line cut by SOP
    enable = 1'b1;
    expect_beat(1'b1, 1'b0, 24'h000000);
    expect_beat(1'b0, 1'b0, 24'h190000);
    expect_beat(1'b0, 1'b1, 24'h4B0000);
    send(1'b1, 1'b0, 24'h000000);
    send(1'b0, 1'b0, 24'h000000);
    send(1'b0, 1'b1, 24'h640000);
    drain();
    expect_beat(1'b1, 1'b0, 24'h000000);
    expect_beat(1'b0, 1'b0, 24'h320000);
    expect_beat(1'b1, 1'b0, 24'h000000);
    send(1'b1, 1'b0, 24'h000000);
    send(1'b0, 1'b0, 24'h280000);
    send(1'b0, 1'b0, 24'h500000);
    send(1'b1, 1'b0, 24'h000000);
    drain();
    check_err(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
